// File: rtl/ring_pkg.sv
// Shared definitions for the ring network node: packet geometry, header field
// positions and the processor-visible NIC register map.
package ring_pkg;

  localparam int unsigned PKT_W   = 64;  // packet width in bits
  localparam int unsigned VC_BIT  = 63;  // virtual channel select (0=even, 1=odd)
  localparam int unsigned DIR_BIT = 30;  // routing direction (router use only)
  localparam int unsigned HOP_MSB = 25;  // hop count field (router use only)
  localparam int unsigned HOP_LSB = 18;

  // NIC register map
  localparam logic [1:0] NIC_RX_DATA = 2'b00;
  localparam logic [1:0] NIC_RX_STAT = 2'b01;
  localparam logic [1:0] NIC_TX_DATA = 2'b10;
  localparam logic [1:0] NIC_TX_STAT = 2'b11;

  typedef enum logic {
    BufEmpty,
    BufFull
  } buf_state_e;

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry packet buffer with a full flag, used for both NIC channels.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset (buffer and flag cleared)
//   load_i    capture data_i; ignored while full
//   unload_i  release the entry; ignored while empty
//   data_i    packet to capture
//   data_o    buffered packet (stale contents remain visible after unload)
//   full_o    entry valid
module nic_chan_buf
  import ring_pkg::*;
#(
  parameter int unsigned Width = PKT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o
);

  buf_state_e       state_q, state_d;
  logic [Width-1:0] data_q, data_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BufEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Full state is sampled before the edge: a load arriving in the same cycle
  // as an unload is dropped, not chained into the freed slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      BufEmpty: begin
        if (load_i) begin
          data_d  = data_i;
          state_d = BufFull;
        end
      end
      BufFull: begin
        if (unload_i) begin
          state_d = BufEmpty;
        end
      end
      default: state_d = BufEmpty;
    endcase
  end

  assign data_o = data_q;
  assign full_o = (state_q == BufFull);

endmodule

// File: rtl/ring_nic.sv
// Processor-side network interface for one ring node (far end of the router
// PE port). Injects processor packets into the router and ejects router
// packets to the processor through a 4-word register map:
//   00 RX data (R)   01 RX status (R) {63'b0,in_full}
//   10 TX data (W)   11 TX status (R) {63'b0,out_full}
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   addr, din, dout        processor register access (dout is combinational)
//   nic_en, nic_wr_en      access strobe and write select
//   net_polarity           router cycle polarity (0=even, 1=odd)
//   net_do/net_so/net_ro   packet, send and ready toward the router
//   net_di/net_si/net_ri   packet, send and ready from the router
//   tx_count, rx_count     completed-transfer counters (RING_NIC_STATS_EN only)
// Optional feature: define RING_NIC_STATS_EN to add the transfer counters.
module ring_nic
  import ring_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic [PKT_W-1:0] din,
  output logic [PKT_W-1:0] dout,
  input  logic             nic_en,
  input  logic             nic_wr_en,
  input  logic             net_polarity,
  output logic [PKT_W-1:0] net_do,
  output logic             net_so,
  input  logic             net_ro,
  input  logic [PKT_W-1:0] net_di,
  input  logic             net_si,
  output logic             net_ri
`ifdef RING_NIC_STATS_EN
  ,
  output logic [15:0]      tx_count,
  output logic [15:0]      rx_count
`endif
);

  logic             rd_en, wr_en;
  logic             tx_load, rx_load, rx_unload;
  logic             out_full, in_full;
  logic [PKT_W-1:0] out_buf, in_buf;

  assign rd_en = nic_en & ~nic_wr_en;
  assign wr_en = nic_en & nic_wr_en;

  // TX channel
  assign tx_load = wr_en & (addr == NIC_TX_DATA);

  nic_chan_buf #(
    .Width (PKT_W)
  ) u_tx_buf (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (tx_load),
    .unload_i (net_so),
    .data_i   (din),
    .data_o   (out_buf),
    .full_o   (out_full)
  );

  // A packet may only leave in the router cycle matching its virtual channel.
  // Derived from the buffer flag so it drops as soon as reset clears it.
  assign net_so = out_full & net_ro & (net_polarity == out_buf[VC_BIT]);
  assign net_do = out_buf;

  // RX channel
  assign net_ri    = ~in_full;
  assign rx_load   = net_si & net_ri;
  assign rx_unload = rd_en & (addr == NIC_RX_DATA) & in_full;

  nic_chan_buf #(
    .Width (PKT_W)
  ) u_rx_buf (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (rx_load),
    .unload_i (rx_unload),
    .data_i   (net_di),
    .data_o   (in_buf),
    .full_o   (in_full)
  );

  // Register read mux
  always_comb begin
    dout = '0;
    if (rd_en) begin
      unique case (addr)
        NIC_RX_DATA: dout = in_buf;
        NIC_RX_STAT: dout = {{(PKT_W-1){1'b0}}, in_full};
        NIC_TX_DATA: dout = '0;
        NIC_TX_STAT: dout = {{(PKT_W-1){1'b0}}, out_full};
        default:     dout = '0;
      endcase
    end
  end

`ifdef RING_NIC_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;
  logic [15:0] rx_count_q, rx_count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  // Counters wrap naturally at 16 bits.
  always_comb begin
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    if (net_so)  tx_count_d = tx_count_q + 16'd1;
    if (rx_load) rx_count_d = rx_count_q + 16'd1;
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_ring_nic.sv
module tb_ring_nic;

  localparam logic [1:0] A_RX_DATA = 2'b00;
  localparam logic [1:0] A_RX_STAT = 2'b01;
  localparam logic [1:0] A_TX_DATA = 2'b10;
  localparam logic [1:0] A_TX_STAT = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] din, dout;
  logic        nic_en, nic_wr_en, net_polarity;
  logic [63:0] net_do, net_di;
  logic        net_so, net_ro, net_si, net_ri;
`ifdef RING_NIC_STATS_EN
  logic [15:0] tx_count, rx_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [63:0] tx_q[$];  // packets expected on net_do when net_so fires
  logic [63:0] rd_q[$];  // expected dout for each processor read

  always #5 clk = ~clk;

  ring_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .din          (din),
    .dout         (dout),
    .nic_en       (nic_en),
    .nic_wr_en    (nic_wr_en),
    .net_polarity (net_polarity),
    .net_do       (net_do),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_di       (net_di),
    .net_si       (net_si),
    .net_ri       (net_ri)
`ifdef RING_NIC_STATS_EN
    ,
    .tx_count     (tx_count),
    .rx_count     (rx_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a packet or a read.
  always @(negedge clk) begin
    if (net_so === 1'b1) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got net_so=1 data 0x%016h expected no send", net_do);
      end else begin
        chk("tx_pkt", net_do, tx_q.pop_front());
      end
    end
    if (nic_en && !nic_wr_en) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected: got read 0x%016h expected no read", dout);
      end else begin
        chk("rd_data", dout, rd_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    nic_en = 1'b1; nic_wr_en = 1'b1; addr = a; din = d;
    idle(1);
    nic_en = 1'b0; nic_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [63:0] exp);
    nic_en = 1'b1; nic_wr_en = 1'b0; addr = a;
    rd_q.push_back(exp);
    idle(1);
    nic_en = 1'b0;
  endtask

  task automatic send(input logic [63:0] pkt);
    net_polarity = pkt[63];
    net_ro = 1'b1;
    tx_q.push_back(pkt);
    wr(A_TX_DATA, pkt);
    idle(1);
  endtask

  task automatic recv(input logic [63:0] d);
    net_di = d; net_si = 1'b1;
    idle(1);
    net_si = 1'b0;
    rd(A_RX_DATA, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; addr = '0; din = '0; nic_en = 1'b0; nic_wr_en = 1'b0;
    net_polarity = 1'b0; net_ro = 1'b0; net_di = '0; net_si = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);

    // 1. Reset state
    chk("rst_net_so", {63'b0, net_so}, 64'd0);
    chk("rst_net_ri", {63'b0, net_ri}, 64'd1);
    chk("rst_net_do", net_do, 64'd0);
    chk("rst_dout_idle", dout, 64'd0);
    rd(A_RX_STAT, 64'd0);
    rd(A_TX_STAT, 64'd0);
    rd(A_RX_DATA, 64'd0);

    // 2. Even packet waits for an even cycle
    net_ro = 1'b1; net_polarity = 1'b1;
    wr(A_TX_DATA, 64'h0123_4567_89AB_CDEF);
    chk("even_wait1", {63'b0, net_so}, 64'd0);
    idle(1);
    chk("even_wait2", {63'b0, net_so}, 64'd0);
    tx_q.push_back(64'h0123_4567_89AB_CDEF);
    net_polarity = 1'b0;
    idle(1);
    chk("even_sent_so", {63'b0, net_so}, 64'd0);
    rd(A_TX_STAT, 64'd0);

    // 3. Odd packet blocked by net_ro; second write dropped
    net_ro = 1'b0; net_polarity = 1'b1;
    wr(A_TX_DATA, 64'h8000_0000_0000_00A5);
    for (int i = 0; i < 5; i++) begin
      chk("blocked_so", {63'b0, net_so}, 64'd0);
      chk("blocked_do", net_do, 64'h8000_0000_0000_00A5);
      if (i == 2) wr(A_TX_DATA, 64'h8000_0000_0000_0BAD);
      else idle(1);
    end
    rd(A_TX_STAT, 64'd1);
    tx_q.push_back(64'h8000_0000_0000_00A5);
    net_ro = 1'b1;
    idle(1);
    net_polarity = 1'b0;
    idle(1);
    net_polarity = 1'b1;
    idle(1);
    rd(A_TX_STAT, 64'd0);
    rd(A_TX_DATA, 64'd0);
    net_ro = 1'b0;

    // 4. RX capture, hold-off while full, read-out, stale read
    net_di = 64'h0000_0000_DEAD_BEEF; net_si = 1'b1;
    idle(1);
    net_si = 1'b0;
    chk("rx_full_ri", {63'b0, net_ri}, 64'd0);
    rd(A_RX_STAT, 64'd1);
    net_di = 64'h0000_0000_1234_5678; net_si = 1'b1;
    idle(2);
    net_si = 1'b0;
    wr(A_RX_STAT, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(A_RX_DATA, 64'h0000_0000_DEAD_BEEF);
    chk("rx_drained_ri", {63'b0, net_ri}, 64'd1);
    rd(A_RX_STAT, 64'd0);
    rd(A_RX_DATA, 64'h0000_0000_DEAD_BEEF);

    // 5. Reset with both channels full
    net_ro = 1'b0; net_polarity = 1'b0;
    wr(A_TX_DATA, 64'h0000_0000_0000_0055);
    net_di = 64'h0000_0000_0000_0066; net_si = 1'b1;
    idle(1);
    net_si = 1'b0;
    chk("pre_rst_ri", {63'b0, net_ri}, 64'd0);
    net_ro = 1'b1;
    #1;
    chk("pre_rst_so", {63'b0, net_so}, 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_so", {63'b0, net_so}, 64'd0);
    chk("async_rst_ri", {63'b0, net_ri}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0; net_ro = 1'b0;
    idle(1);
    rd(A_RX_STAT, 64'd0);
    rd(A_TX_STAT, 64'd0);
    chk("post_rst_do", net_do, 64'd0);

`ifdef RING_NIC_STATS_EN
    // 6. Transfer counters and wrap
    send(64'h0000_0000_0000_0001);
    send(64'h8000_0000_0000_0002);
    send(64'h0000_0000_0000_0003);
    recv(64'h0000_0000_0000_00C1);
    recv(64'h0000_0000_0000_00C2);
    chk("tx_count3", {48'b0, tx_count}, 64'd3);
    chk("rx_count2", {48'b0, rx_count}, 64'd2);
    force dut.tx_count_q = 16'hFFFF;
    #1;
    release dut.tx_count_q;
    chk("tx_count_pre", {48'b0, tx_count}, 64'hFFFF);
    send(64'h8000_0000_0000_0004);
    chk("tx_count_wrap", {48'b0, tx_count}, 64'd0);
`endif

    net_ro = 1'b0;
    idle(2);
    chk("tx_q_drained", 64'(tx_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
